// File: rtl/bp_pkg.sv
// Shared types, counter encodings and PC slicing helpers for the branch predictor.
// Optional gshare indexing is selected with the BP_GSHARE_EN macro.
package bp_pkg;

    localparam int BP_DATA_W = 64;
    localparam int BP_TAG_W  = 8;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic                 is_jump;
        logic [BP_TAG_W-1:0]  tag;
        logic [BP_DATA_W-1:0] target;
    } btb_entry_t;

    // Word index of a PC, masked to idx_w bits (byte offset dropped).
    function automatic logic [31:0] pc_index(input logic [BP_DATA_W-1:0] pc,
                                             input int unsigned       idx_w);
        logic [BP_DATA_W-1:0] mask_v;
        mask_v = ~({BP_DATA_W{1'b1}} << idx_w);
        return 32'((pc >> 32'd2) & mask_v);
    endfunction

    // Tag bits sitting directly above a bidx_w-bit word index.
    function automatic logic [BP_TAG_W-1:0] pc_tag(input logic [BP_DATA_W-1:0] pc,
                                                   input int unsigned       bidx_w);
        return BP_TAG_W'(pc >> (bidx_w + 32'd2));
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic of a 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    // Step towards the observed outcome, holding at either extreme
    always_comb begin
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: 2-bit BHT plus direct-mapped BTB with misprediction counter.
// Define BP_GSHARE_EN to XOR a global history register into the BHT index.
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int DATA_W      = BP_DATA_W,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_W       = BP_TAG_W,
    parameter int GHR_W       = 6
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] lookup_pc,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_target,
    output logic              btb_hit,
    input  logic              upd_valid,
    input  logic [DATA_W-1:0] upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [DATA_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [DATA_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       mispred_cnt
);

    localparam int IDX_W  = $clog2(BHT_ENTRIES);
    localparam int BIDX_W = $clog2(BTB_ENTRIES);

    logic [1:0]        ctr_r [BHT_ENTRIES];
    btb_entry_t        btb_r [BTB_ENTRIES];
    logic [31:0]       mispred_cnt_r;

    logic [IDX_W-1:0]  lk_bht_idx_s;
    logic [IDX_W-1:0]  upd_bht_idx_s;
    logic [BIDX_W-1:0] lk_btb_idx_s;
    logic [BIDX_W-1:0] upd_btb_idx_s;
    btb_entry_t        lk_entry_s;
    btb_entry_t        upd_entry_s;
    logic [1:0]        ctr_nxt_s;
    logic              taken_eff_s;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0]  ghr_r;
`else
    logic              unused_cfg_s;
    assign unused_cfg_s = ^(32'(GHR_W));
`endif

    // Table indices for the fetch and resolve ports
    always_comb begin
        lk_bht_idx_s  = IDX_W'(pc_index(lookup_pc, IDX_W));
        upd_bht_idx_s = IDX_W'(pc_index(upd_pc, IDX_W));
`ifdef BP_GSHARE_EN
        lk_bht_idx_s  = lk_bht_idx_s ^ IDX_W'(ghr_r);
        upd_bht_idx_s = upd_bht_idx_s ^ IDX_W'(ghr_r);
`endif
        lk_btb_idx_s  = BIDX_W'(pc_index(lookup_pc, BIDX_W));
        upd_btb_idx_s = BIDX_W'(pc_index(upd_pc, BIDX_W));
    end

    // Zero-latency lookup straight from the state registers, no update bypass
    always_comb begin
        lk_entry_s = btb_r[lk_btb_idx_s];
        btb_hit    = lk_entry_s.valid && (lk_entry_s.tag == pc_tag(lookup_pc, BIDX_W));
        pred_taken = btb_hit && (lk_entry_s.is_jump || ctr_r[lk_bht_idx_s][1]);
        if (pred_taken) begin
            pred_target = lk_entry_s.target;
        end else begin
            pred_target = lookup_pc + DATA_W'(4);
        end
    end

    // Resolution check: jumps always count as taken
    always_comb begin
        taken_eff_s = upd_is_jump || upd_taken;
        mispredict  = upd_valid &&
                      ((upd_pred_taken != taken_eff_s) ||
                       (taken_eff_s && (upd_pred_target != upd_target)));
        upd_entry_s = '{valid: 1'b1, is_jump: upd_is_jump,
                        tag: pc_tag(upd_pc, BIDX_W), target: upd_target};
    end

    bp_sat_counter u_sat_counter (
        .cur   (ctr_r[upd_bht_idx_s]),
        .taken (upd_taken),
        .nxt   (ctr_nxt_s)
    );

    // Counter and BTB writeback; not-taken branches never allocate
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_r[i] <= WNT;
            end
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_r[i] <= '0;
            end
        end else if (en && upd_valid) begin
            if (upd_is_jump) begin
                btb_r[upd_btb_idx_s] <= upd_entry_s;
            end else begin
                ctr_r[upd_bht_idx_s] <= ctr_nxt_s;
                if (upd_taken) begin
                    btb_r[upd_btb_idx_s] <= upd_entry_s;
                end
            end
        end
    end

`ifdef BP_GSHARE_EN
    // Global history shifts only on conditional outcomes
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ghr_r <= '0;
        end else if (en && upd_valid && !upd_is_jump) begin
            ghr_r <= {ghr_r[GHR_W-2:0], upd_taken};
        end
    end
`endif

    // Saturating misprediction counter
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mispred_cnt_r <= 32'd0;
        end else if (en && mispredict && (mispred_cnt_r != 32'hFFFF_FFFF)) begin
            mispred_cnt_r <= mispred_cnt_r + 32'd1;
        end
    end

    assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Randomised and directed bench for branch_predictor_unit against a behavioural model.
// Gshare-specific steps are compiled in when BP_GSHARE_EN is defined.
module tb_branch_predictor_unit;

    localparam int BHT = 64;
    localparam int BTB = 16;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        en;
    logic [63:0] lookup_pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        btb_hit;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_pred_taken;
    logic [63:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] mispred_cnt;

    always #5 clk = ~clk;

    branch_predictor_unit dut (
        .clk(clk), .arst_n(arst_n), .en(en), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .btb_hit(btb_hit),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .mispred_cnt(mispred_cnt)
    );

    // Behavioural model: counters as integers 0..3, BTB as plain arrays
    int unsigned    m_ctr [BHT];
    bit             m_val [BTB];
    bit             m_jmp [BTB];
    logic [63:0]    m_tgt [BTB];
    longint unsigned m_tag [BTB];
    longint unsigned m_cnt;
    int unsigned    m_ghr;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int i = 0; i < BHT; i++) m_ctr[i] = 1;
        for (int i = 0; i < BTB; i++) begin
            m_val[i] = 1'b0; m_jmp[i] = 1'b0; m_tgt[i] = 64'd0; m_tag[i] = 0;
        end
        m_cnt = 0;
        m_ghr = 0;
    endtask

    function automatic int unsigned bht_of(logic [63:0] pc);
        int unsigned i;
        i = int'((pc / 4) % BHT);
`ifdef BP_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    function automatic int unsigned btb_of(logic [63:0] pc);
        return int'((pc / 4) % BTB);
    endfunction

    function automatic longint unsigned tag_of(logic [63:0] pc);
        return longint'((pc / (4 * BTB)) % 256);
    endfunction

    function automatic bit m_hit(logic [63:0] pc);
        return m_val[btb_of(pc)] && (m_tag[btb_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_ptaken(logic [63:0] pc);
        return m_hit(pc) && (m_jmp[btb_of(pc)] || (m_ctr[bht_of(pc)] >= 2));
    endfunction

    function automatic logic [63:0] m_ptarget(logic [63:0] pc);
        logic [63:0] nxt;
        nxt = pc + 64'd4;
        return m_ptaken(pc) ? m_tgt[btb_of(pc)] : nxt;
    endfunction

    function automatic bit m_misp();
        bit te;
        te = upd_is_jump || upd_taken;
        return upd_valid && ((upd_pred_taken != te) || (te && (upd_pred_target != upd_target)));
    endfunction

    task automatic model_update();
        int unsigned bi, ti;
        bit mp;
        mp = m_misp();
        if (en && upd_valid) begin
            bi = bht_of(upd_pc);
            ti = btb_of(upd_pc);
            if (upd_is_jump || upd_taken) begin
                m_val[ti] = 1'b1; m_jmp[ti] = upd_is_jump;
                m_tgt[ti] = upd_target; m_tag[ti] = tag_of(upd_pc);
            end
            if (!upd_is_jump) begin
                if (upd_taken) m_ctr[bi] = (m_ctr[bi] == 3) ? 3 : m_ctr[bi] + 1;
                else           m_ctr[bi] = (m_ctr[bi] == 0) ? 0 : m_ctr[bi] - 1;
                m_ghr = ((m_ghr * 2) + (upd_taken ? 1 : 0)) % 64;
            end
        end
        if (en && mp && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("btb_hit", 64'(btb_hit), 64'(m_hit(lookup_pc)));
        chk("pred_taken", 64'(pred_taken), 64'(m_ptaken(lookup_pc)));
        chk("pred_target", pred_target, m_ptarget(lookup_pc));
        chk("mispredict", 64'(mispredict), 64'(m_misp()));
        chk("mispred_cnt", 64'(mispred_cnt), m_cnt);
    endtask

    // One cycle: drive after the falling edge, check, then clock the model
    task automatic go(input logic [63:0] lpc, input bit v, input logic [63:0] upc,
                      input bit j, input bit t, input logic [63:0] tgt,
                      input bit ppt, input logic [63:0] ppg, input bit e);
        lookup_pc = lpc; upd_valid = v; upd_pc = upc; upd_is_jump = j;
        upd_taken = t; upd_target = tgt; upd_pred_taken = ppt;
        upd_pred_target = ppg; en = e;
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic look(input logic [63:0] pc);
        go(pc, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic br(input logic [63:0] pc, input bit t, input logic [63:0] tgt);
        go(pc, 1'b1, pc, 1'b0, t, tgt, 1'b0, pc + 64'd4, 1'b1);
    endtask

    logic [63:0] pool [8];

    initial begin
        pool[0] = 64'h100; pool[1] = 64'h140; pool[2] = 64'h180; pool[3] = 64'h200;
        pool[4] = 64'h1100; pool[5] = 64'h104; pool[6] = 64'h400; pool[7] = 64'h2C0;
        arst_n = 1'b0; en = 1'b0; lookup_pc = 64'h40; upd_valid = 1'b0; upd_pc = 64'd0;
        upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = 64'd0;
        upd_pred_taken = 1'b0; upd_pred_target = 64'd0;
        model_reset();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        // Reset state and pc+4 wrap
        look(64'h40);
        chk("rst_target", pred_target, 64'h44);
        chk("rst_cnt", 64'(mispred_cnt), 64'd0);
        look(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_target", pred_target, 64'd0);

        // Branch training: taken twice, then not-taken three times
        br(64'h100, 1'b1, 64'h80);
        br(64'h100, 1'b1, 64'h80);
        look(64'h100);
`ifndef BP_GSHARE_EN
        chk("t2_taken", 64'(pred_taken), 64'd1);
        chk("t2_target", pred_target, 64'h80);
`endif
        repeat (3) br(64'h100, 1'b0, 64'h80);
        look(64'h100);
        chk("t2_hit_after_nt", 64'(btb_hit), 64'd1);
`ifndef BP_GSHARE_EN
        chk("t2_nt", 64'(pred_taken), 64'd0);
`endif

        // Unconditional jump predicted taken regardless of counter
        go(64'h200, 1'b1, 64'h200, 1'b1, 1'b0, 64'h300, 1'b0, 64'h204, 1'b1);
        look(64'h200);
        chk("t3_jump_taken", 64'(pred_taken), 64'd1);
        chk("t3_jump_target", pred_target, 64'h300);

        // Alias eviction, then same-cycle lookup/update sees the old entry
        br(64'h100, 1'b1, 64'h80);
        br(64'h140, 1'b1, 64'h500);
        look(64'h100);
        chk("t4_alias_miss", 64'(btb_hit), 64'd0);
        lookup_pc = 64'h100; upd_valid = 1'b1; upd_pc = 64'h100; upd_is_jump = 1'b0;
        upd_taken = 1'b1; upd_target = 64'h80; upd_pred_taken = 1'b0;
        upd_pred_target = 64'h104; en = 1'b1;
        #1;
        chk("t4_same_cycle_old", 64'(btb_hit), 64'd0);
        check_all();
        @(posedge clk); model_update(); @(negedge clk);
        look(64'h100);
        chk("t4_after_write", 64'(btb_hit), 64'd1);

        // Mispredict counting: direction wrong, target wrong, frozen when en=0
        go(64'h600, 1'b1, 64'h600, 1'b0, 1'b1, 64'h700, 1'b0, 64'h604, 1'b1);
        go(64'h600, 1'b1, 64'h600, 1'b0, 1'b1, 64'h700, 1'b1, 64'h780, 1'b1);
        go(64'h600, 1'b1, 64'h600, 1'b1, 1'b0, 64'h900, 1'b0, 64'h604, 1'b0);
        look(64'h600);

        // Saturation at all-ones
        force dut.mispred_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.mispred_cnt_r;
        m_cnt = 64'hFFFF_FFFE;
        repeat (3) go(64'h600, 1'b1, 64'h600, 1'b0, 1'b1, 64'h700, 1'b0, 64'h604, 1'b1);
        chk("t5_saturated", 64'(mispred_cnt), 64'hFFFF_FFFF);

        // Asynchronous reset in the middle of an update cycle
        lookup_pc = 64'h100; upd_valid = 1'b1; upd_pc = 64'h100; upd_taken = 1'b1;
        upd_is_jump = 1'b0; upd_target = 64'h80; en = 1'b1;
        #1;
        arst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_hit", 64'(btb_hit), 64'd0);
        chk("rst_mid_taken", 64'(pred_taken), 64'd0);
        chk("rst_mid_target", pred_target, 64'h104);
        chk("rst_mid_cnt", 64'(mispred_cnt), 64'd0);
        upd_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        look(64'h200);

`ifdef BP_GSHARE_EN
        // Alternating T,N,T,N at one PC becomes perfectly predicted
        for (int k = 0; k < 24; k++) begin
            lookup_pc = 64'h400; upd_valid = 1'b1; upd_pc = 64'h400; upd_is_jump = 1'b0;
            upd_taken = (k % 2 == 0); upd_target = 64'h480; en = 1'b1;
            upd_pred_taken = 1'b0; upd_pred_target = 64'h404;
            #1;
            if (k >= 8) chk("gshare_alt", 64'(pred_taken), 64'(k % 2 == 0));
            check_all();
            @(posedge clk); model_update(); @(negedge clk);
        end
`endif

        // Random traffic over a small PC pool to provoke hits and aliases
        for (int n = 0; n < 400; n++) begin
            logic [63:0] lpc, upc, tgt, ppg;
            bit j, t, ppt, e, v;
            lpc = pool[$urandom_range(0, 7)];
            upc = pool[$urandom_range(0, 7)];
            v   = ($urandom_range(0, 3) != 0);
            j   = ($urandom_range(0, 4) == 0);
            t   = $urandom_range(0, 1) == 1;
            e   = ($urandom_range(0, 7) != 0);
            tgt = 64'($urandom_range(0, 255)) * 64'd4 + 64'h8000;
            ppt = ($urandom_range(0, 1) == 1) ? m_ptaken(upc) : ($urandom_range(0, 1) == 1);
            ppg = ($urandom_range(0, 1) == 1) ? m_ptarget(upc) : tgt;
            go(lpc, v, upc, j, t, tgt, ppt, ppg, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
